// File: rtl/puf_cr_sequencer_if.sv
// puf_cr_sequencer_if
// Bundles the request/response handshake and the delay-line drive signals
// of the PUF challenge/response sequencer.
//   start, challenge_in, resp_ack : request side, driven by the consumer
//   puf_resp                      : raw arbiter outputs (asynchronous)
//   puf_challenge, puf_pulse      : registered drive into the delay lines
//   busy, resp_valid              : sequencer status
//   response, stable              : voted result and per-bit unanimity
// The slave modport is the sequencer's view. The master modport is the
// environment's view (consumer plus PUF core).
interface puf_cr_sequencer_if #(
  parameter int CH_W  = 8,
  parameter int N_PUF = 7
);
  logic             start;
  logic [CH_W-1:0]  challenge_in;
  logic             resp_ack;
  logic [N_PUF-1:0] puf_resp;
  logic [CH_W-1:0]  puf_challenge;
  logic             puf_pulse;
  logic             busy;
  logic             resp_valid;
  logic [N_PUF-1:0] response;
  logic [N_PUF-1:0] stable;

  modport master (
    output start, challenge_in, resp_ack, puf_resp,
    input  puf_challenge, puf_pulse, busy, resp_valid, response, stable
  );

  modport slave (
    input  start, challenge_in, resp_ack, puf_resp,
    output puf_challenge, puf_pulse, busy, resp_valid, response, stable
  );
endinterface

// File: rtl/puf_cr_sequencer.sv
// puf_cr_sequencer
// Drives an arbiter PUF through VOTE_N launch repetitions of one challenge.
// It majority-votes each response bit and flags the bits that were unanimous.
// Each repetition is SETTLE_CYC cycles with the pulse low, SETTLE_CYC cycles
// with it high, and one sample cycle with it still high. The result is held
// until the consumer acknowledges it.
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : puf_cr_sequencer_if.slave (handshake, delay-line drive, result)
module puf_cr_sequencer #(
  parameter int CH_W       = 8,
  parameter int N_PUF      = 7,
  parameter int VOTE_N     = 7,
  parameter int SETTLE_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  puf_cr_sequencer_if.slave    bus
);

  localparam int TW = $clog2(VOTE_N + 1);
  localparam int PW = $clog2(SETTLE_CYC);
  localparam logic [TW-1:0] VOTE_HALF = TW'(VOTE_N / 2);
  localparam logic [TW-1:0] VOTE_ALL  = TW'(VOTE_N);
  localparam logic [TW-1:0] REP_LAST  = TW'(VOTE_N - 1);
  localparam logic [PW-1:0] PH_LAST   = PW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOW,
    HIGH,
    SAMPLE,
    RESULT
  } state_t;

  state_t           state;
  logic [PW-1:0]    phase_cnt;
  logic [TW-1:0]    rep_cnt;
  logic [TW-1:0]    tally [N_PUF];
  logic [TW-1:0]    tally_inc [N_PUF];
  logic [N_PUF-1:0] sync1;
  logic [N_PUF-1:0] sync2;
  logic [N_PUF-1:0] resp_next;
  logic [N_PUF-1:0] stable_next;
  logic [CH_W-1:0]  challenge_q;
  logic             pulse_q;
  logic             busy_q;
  logic             valid_q;
  logic [N_PUF-1:0] response_q;
  logic [N_PUF-1:0] stable_q;

  // The arbiter outputs settle with no relation to clk. Each bit passes
  // through two flops before it can reach a tally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= bus.puf_resp;
      sync2 <= sync1;
    end
  end

  // The tally for the current sample is formed here. This lets the final
  // repetition's bit count in the vote that is registered on the same edge
  // that enters RESULT. The majority threshold is strictly more than half,
  // which is unambiguous because VOTE_N is odd.
  always_comb begin
    resp_next   = '0;
    stable_next = '0;
    for (int i = 0; i < N_PUF; i++) begin
      tally_inc[i]   = tally[i] + TW'(sync2[i]);
      resp_next[i]   = (tally_inc[i] > VOTE_HALF);
      stable_next[i] = (tally_inc[i] == '0) || (tally_inc[i] == VOTE_ALL);
    end
  end

  // Sequencer FSM. All outputs are registered and are set from the state
  // being entered, so each output changes on the same edge as the state.
  // Start is only looked at in IDLE. The result is registered when RESULT
  // is entered and then held, through IDLE as well, until the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      phase_cnt   <= '0;
      rep_cnt     <= '0;
      challenge_q <= '0;
      pulse_q     <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      response_q  <= '0;
      stable_q    <= '0;
      for (int i = 0; i < N_PUF; i++) begin
        tally[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            challenge_q <= bus.challenge_in;
            rep_cnt     <= '0;
            phase_cnt   <= '0;
            for (int i = 0; i < N_PUF; i++) begin
              tally[i] <= '0;
            end
            pulse_q <= 1'b0;
            busy_q  <= 1'b1;
            state   <= LOW;
          end
        end
        LOW: begin
          if (phase_cnt == PH_LAST) begin
            phase_cnt <= '0;
            pulse_q   <= 1'b1;
            state     <= HIGH;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        HIGH: begin
          if (phase_cnt == PH_LAST) begin
            phase_cnt <= '0;
            state     <= SAMPLE;
          end else begin
            phase_cnt <= phase_cnt + PW'(1);
          end
        end
        SAMPLE: begin
          for (int i = 0; i < N_PUF; i++) begin
            tally[i] <= tally_inc[i];
          end
          rep_cnt <= rep_cnt + TW'(1);
          pulse_q <= 1'b0;
          if (rep_cnt == REP_LAST) begin
            response_q <= resp_next;
            stable_q   <= stable_next;
            valid_q    <= 1'b1;
            state      <= RESULT;
          end else begin
            state <= LOW;
          end
        end
        RESULT: begin
          if (bus.resp_ack) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          pulse_q <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  // The interface outputs come straight from their registers.
  assign bus.puf_challenge = challenge_q;
  assign bus.puf_pulse     = pulse_q;
  assign bus.busy          = busy_q;
  assign bus.resp_valid    = valid_q;
  assign bus.response      = response_q;
  assign bus.stable        = stable_q;

endmodule

// File: tb/tb_puf_cr_sequencer.sv
// tb_puf_cr_sequencer
// Directed bench for puf_cr_sequencer with default parameters.
// The stimulus tasks push each expected vote result into a queue.
// An independent monitor pops the queue when resp_valid rises. It checks
// the response, the stable flags, the latency from acceptance, and that the
// result stays steady while valid.
module tb_puf_cr_sequencer;

  localparam int CH_W       = 8;
  localparam int N_PUF      = 7;
  localparam int VOTE_N     = 7;
  localparam int SETTLE_CYC = 4;
  localparam int REP_LEN    = 2 * SETTLE_CYC + 1;
  localparam int LAT        = VOTE_N * REP_LEN;

  typedef struct packed {
    logic [N_PUF-1:0] resp;
    logic [N_PUF-1:0] stab;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  exp_t exp_q [$];
  logic [N_PUF-1:0] rep_pat [VOTE_N];

  puf_cr_sequencer_if #(.CH_W(CH_W), .N_PUF(N_PUF)) bus ();

  puf_cr_sequencer #(
    .CH_W(CH_W), .N_PUF(N_PUF), .VOTE_N(VOTE_N), .SETTLE_CYC(SETTLE_CYC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  // Free-running clock and an edge counter used for latency measurement.
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Records one comparison and reports it if it differs.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, required);
    end
  endtask

  // Monitor: notes the acceptance cycle when busy rises. When resp_valid
  // rises it scores the result against the queue. It then watches the
  // result for changes while it stays valid.
  logic             prev_valid = 1'b0;
  logic             prev_busy  = 1'b0;
  int               acc_cyc    = 0;
  logic             hold_bad   = 1'b0;
  logic [N_PUF-1:0] held_resp  = '0;
  logic [N_PUF-1:0] held_stab  = '0;
  exp_t             cur;

  always @(negedge clk) begin
    if (bus.busy && !prev_busy) acc_cyc = cyc;
    if (bus.resp_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_valid", 32'(bus.resp_valid), 32'd0);
      end else begin
        cur = exp_q.pop_front();
        checkOutput("response", 32'(bus.response), 32'(cur.resp));
        checkOutput("stable", 32'(bus.stable), 32'(cur.stab));
        checkOutput("latency", 32'(cyc - acc_cyc), 32'(LAT));
      end
      held_resp = bus.response;
      held_stab = bus.stable;
      hold_bad  = 1'b0;
    end else if (bus.resp_valid) begin
      if (bus.response !== held_resp || bus.stable !== held_stab) hold_bad = 1'b1;
    end
    if (!bus.resp_valid && prev_valid) checkOutput("hold_steady", 32'(hold_bad), 32'd0);
    prev_valid = bus.resp_valid;
    prev_busy  = bus.busy;
  end

  // Runs one full challenge using the per-repetition patterns in rep_pat.
  // The call starts at a falling edge. It can pulse start mid-run, hold off
  // the acknowledge, or raise start together with the acknowledge.
  task automatic applyStimulus(input logic [CH_W-1:0] ch,
                               input logic [N_PUF-1:0] exp_resp,
                               input logic [N_PUF-1:0] exp_stab,
                               input int hold_cyc,
                               input bit inject_start,
                               input bit ack_with_start);
    exp_t item;
    bit   bad;
    item.resp = exp_resp;
    item.stab = exp_stab;
    exp_q.push_back(item);
    bus.challenge_in = ch;
    bus.puf_resp     = rep_pat[0];
    bus.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start        = 1'b0;
    bus.challenge_in = '0;
    checkOutput("challenge_latched", 32'(bus.puf_challenge), 32'(ch));
    bad = 1'b0;
    for (int e = 0; e < LAT; e++) begin
      if ((e % REP_LEN) == 0) bus.puf_resp = rep_pat[e / REP_LEN];
      if (inject_start && e == 20) begin
        bus.start        = 1'b1;
        bus.challenge_in = 8'h3C;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.puf_pulse !== ((e % REP_LEN) >= SETTLE_CYC) ||
          bus.busy !== 1'b1 || bus.resp_valid !== 1'b0) bad = 1'b1;
      @(negedge clk);
    end
    checkOutput("pulse_sequence", 32'(bad), 32'd0);
    checkOutput("challenge_held", 32'(bus.puf_challenge), 32'(ch));
    checkOutput("pulse_in_result", 32'(bus.puf_pulse), 32'd0);
    checkOutput("valid_in_result", 32'(bus.resp_valid), 32'd1);
    repeat (hold_cyc) @(negedge clk);
    checkOutput("valid_after_hold", 32'(bus.resp_valid), 32'd1);
    bus.resp_ack = 1'b1;
    if (ack_with_start) begin
      bus.start        = 1'b1;
      bus.challenge_in = 8'hFF;
    end
    @(posedge clk);
    @(negedge clk);
    bus.resp_ack = 1'b0;
    bus.start    = 1'b0;
    checkOutput("busy_after_ack", 32'(bus.busy), 32'd0);
    checkOutput("valid_after_ack", 32'(bus.resp_valid), 32'd0);
    checkOutput("pulse_in_idle", 32'(bus.puf_pulse), 32'd0);
    checkOutput("response_kept", 32'(bus.response), 32'(exp_resp));
    checkOutput("stable_kept", 32'(bus.stable), 32'(exp_stab));
    repeat (2) @(negedge clk);
  endtask

  // Aborts a run with reset during the HIGH phase of the third repetition.
  // Checks that everything clears immediately. The monitor flags any valid
  // that appears afterwards.
  task automatic applyReset();
    bus.challenge_in = 8'h11;
    bus.puf_resp     = 7'h7F;
    bus.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2 * REP_LEN + SETTLE_CYC + 1) @(negedge clk);
    checkOutput("pulse_before_reset", 32'(bus.puf_pulse), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_pulse", 32'(bus.puf_pulse), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("reset_challenge", 32'(bus.puf_challenge), 32'd0);
    checkOutput("reset_response", 32'(bus.response), 32'd0);
    checkOutput("reset_stable", 32'(bus.stable), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 10) @(negedge clk);
    checkOutput("idle_after_abort", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start        = 1'b0;
    bus.challenge_in = '0;
    bus.resp_ack     = 1'b0;
    bus.puf_resp     = '0;
    repeat (3) @(negedge clk);
    checkOutput("por_busy", 32'(bus.busy), 32'd0);
    checkOutput("por_valid", 32'(bus.resp_valid), 32'd0);
    checkOutput("por_pulse", 32'(bus.puf_pulse), 32'd0);
    checkOutput("por_challenge", 32'(bus.puf_challenge), 32'd0);
    checkOutput("por_response", 32'(bus.response), 32'd0);
    checkOutput("por_stable", 32'(bus.stable), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // All repetitions 0x55, result held for 20 cycles.
    rep_pat = '{7'h55, 7'h55, 7'h55, 7'h55, 7'h55, 7'h55, 7'h55};
    applyStimulus(8'hA5, 7'h55, 7'h7F, 20, 1'b0, 1'b0);

    // Bit0 alternates 1,0,1,0,1,0,1, giving 4 of 7.
    rep_pat = '{7'h01, 7'h00, 7'h01, 7'h00, 7'h01, 7'h00, 7'h01};
    applyStimulus(8'h01, 7'h01, 7'h7E, 1, 1'b0, 1'b0);

    // Bit3 set in 3 of 7 and bit6 always set.
    rep_pat = '{7'h48, 7'h40, 7'h48, 7'h40, 7'h48, 7'h40, 7'h40};
    applyStimulus(8'h5A, 7'h40, 7'h77, 1, 1'b0, 1'b0);

    // Bit3 set in 4 of 7 and bit1 in 6 of 7. Start is pulsed while busy,
    // and start is raised together with the acknowledge.
    rep_pat = '{7'h00, 7'h0A, 7'h02, 7'h0A, 7'h02, 7'h0A, 7'h0A};
    applyStimulus(8'hC3, 7'h0A, 7'h75, 3, 1'b1, 1'b1);

    applyReset();

    // Normal run after the abort.
    rep_pat = '{7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A, 7'h2A};
    applyStimulus(8'hA5, 7'h2A, 7'h7F, 1, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
